// File: rtl/segment_led_decoder.sv
// Receive-side decoder for the 9-bit segment-LED bus (S,P,GFEDCBA): debounce, lock, decode to hex + dp.
// Define SEG_DEC_ACTIVE_LOW_EN for common-anode (active-low) segment and dp inputs.
module segment_led_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [8:0]       seg_in,
  output logic [3:0]       digit,
  output logic             dp,
  output logic             digit_valid,
  output logic             blank,
  output logic             illegal,
  output logic             update,
  output logic [CNT_W-1:0] change_cnt
);

  typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_LOCKED} state_t;

  localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [8:0]       seg_pol;
  logic [8:0]       sync1_q, s_q;
  logic [8:0]       h_q, h_d;
  logic [8:0]       acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic [3:0]       digit_q, digit_d;
  logic             dp_q, dp_d, valid_q, valid_d, blank_q, blank_d;
  logic             illegal_q, illegal_d, update_q, update_d;
  logic [CNT_W-1:0] cc_q, cc_d;
  logic             change, accept;
  logic [4:0]       dec;

`ifdef SEG_DEC_ACTIVE_LOW_EN
  assign seg_pol = {seg_in[8], ~seg_in[7:0]};
`else
  assign seg_pol = seg_in;
`endif

  // Returns {legal, value}; any code outside the hex table is flagged illegal.
  function automatic logic [4:0] decode(input logic [6:0] code);
    case (code)
      7'h3F:   return 5'h10;
      7'h06:   return 5'h11;
      7'h5B:   return 5'h12;
      7'h4F:   return 5'h13;
      7'h66:   return 5'h14;
      7'h6D:   return 5'h15;
      7'h7D:   return 5'h16;
      7'h07:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h6F:   return 5'h19;
      7'h77:   return 5'h1A;
      7'h7C:   return 5'h1B;
      7'h39:   return 5'h1C;
      7'h5E:   return 5'h1D;
      7'h79:   return 5'h1E;
      7'h71:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign change  = (s_q != h_q);
  assign cnt_inc = cnt_q + 16'd1;
  assign dec     = decode(h_q[6:0]);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_BLANK;
    else           state_q <= state_d;
  end

  // Next state: h itself counts as the first stable sample, so acceptance
  // happens when the incremented count reaches STABLE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (change) begin
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE && cnt_inc == LAST_CNT) begin
      accept  = 1'b1;
      state_d = h_q[8] ? ST_BLANK : ST_LOCKED;
    end
  end

  always_comb begin
    h_d       = h_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    digit_d   = digit_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    illegal_d = illegal_q;
    update_d  = 1'b0;
    cc_d      = cc_q;
    if (change) begin
      h_d   = s_q;
      cnt_d = '0;
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_inc;
      if (accept) begin
        cnt_d = '0;
        acc_d = h_q;
        if (h_q != acc_q) begin
          update_d = 1'b1;
          if (cc_q != '1) cc_d = cc_q + 1'b1;
        end
        if (h_q[8]) begin
          blank_d   = 1'b1;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
        end else begin
          blank_d   = 1'b0;
          dp_d      = h_q[7];
          valid_d   = dec[4];
          illegal_d = ~dec[4];
          if (dec[4]) digit_d = dec[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q   <= 9'h100;
      s_q       <= 9'h100;
      h_q       <= 9'h100;
      acc_q     <= 9'h100;
      cnt_q     <= '0;
      digit_q   <= '0;
      dp_q      <= 1'b0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      illegal_q <= 1'b0;
      update_q  <= 1'b0;
      cc_q      <= '0;
    end else begin
      sync1_q   <= seg_pol;
      s_q       <= sync1_q;
      h_q       <= h_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      illegal_q <= illegal_d;
      update_q  <= update_d;
      cc_q      <= cc_d;
    end
  end

  // Outputs
  always_comb begin
    digit       = digit_q;
    dp          = dp_q;
    digit_valid = valid_q;
    blank       = blank_q;
    illegal     = illegal_q;
    update      = update_q;
    change_cnt  = cc_q;
  end

endmodule

// File: tb/tb_segment_led_decoder.sv
// Directed bench for segment_led_decoder: two instances (CNT_W=8 and CNT_W=2), STABLE_CYCLES=4.
module tb_segment_led_decoder;
  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [8:0] seg_a, seg_b;
  logic [3:0] digit_a, digit_b;
  logic       dp_a, dp_b, valid_a, valid_b, blank_a, blank_b;
  logic       illegal_a, illegal_b, update_a, update_b;
  logic [7:0] cc_a;
  logic [1:0] cc_b;
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  segment_led_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .seg_in(seg_a), .digit(digit_a), .dp(dp_a),
    .digit_valid(valid_a), .blank(blank_a), .illegal(illegal_a), .update(update_a),
    .change_cnt(cc_a));

  segment_led_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .seg_in(seg_b), .digit(digit_b), .dp(dp_b),
    .digit_valid(valid_b), .blank(blank_b), .illegal(illegal_b), .update(update_b),
    .change_cnt(cc_b));

  function automatic logic [8:0] enc(input logic [8:0] x);
`ifdef SEG_DEC_ACTIVE_LOW_EN
    return {x[8], ~x[7:0]};
`else
    return x;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    seg_a = enc(9'h100);
    seg_b = enc(9'h100);
    rst_n_in = 1'b0;
    tick(3);
    checks++;
    if ({digit_a, dp_a, valid_a, blank_a, illegal_a, update_a, cc_a} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_a: got digit=%h dp=%b v=%b blank=%b ill=%b upd=%b cc=%0d, want 0 0 0 1 0 0 0",
               digit_a, dp_a, valid_a, blank_a, illegal_a, update_a, cc_a);
    end
    rst_n_in = 1'b1;
    tick(4);
    checks++;
    if (update_a !== 1'b0 || blank_a !== 1'b1 || cc_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: got upd=%b blank=%b cc=%0d, want 0 1 0", update_a, blank_a, cc_a);
    end
  endtask

  task automatic test_first_lock;
    seg_a = enc(9'h03F);
    tick(5);
    checks++;
    if (valid_a !== 1'b0 || update_a !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got v=%b upd=%b, want 0 0", valid_a, update_a);
    end
    tick(1);
    checks++;
    if ({digit_a, dp_a, valid_a, blank_a, update_a, cc_a} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL lock_0: got digit=%h dp=%b v=%b blank=%b upd=%b cc=%0d, want 0 0 1 0 1 1",
               digit_a, dp_a, valid_a, blank_a, update_a, cc_a);
    end
    tick(1);
    checks++;
    if (update_a !== 1'b0) begin
      errors++;
      $display("FAIL update_width: got %b want 0", update_a);
    end
  endtask

  task automatic test_dp_digit;
    seg_a = enc(9'h0E6);
    tick(6);
    checks++;
    if ({digit_a, dp_a, valid_a, update_a, cc_a} !== {4'h4, 1'b1, 1'b1, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL lock_4dp: got digit=%h dp=%b v=%b upd=%b cc=%0d, want 4 1 1 1 2",
               digit_a, dp_a, valid_a, update_a, cc_a);
    end
    tick(1);
  endtask

  task automatic test_glitch;
    int bad = 0;
    seg_a = enc(9'h07F);
    tick(2);
    seg_a = enc(9'h0E6);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (update_a !== 1'b0 || digit_a !== 4'h4 || dp_a !== 1'b1 || valid_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || cc_a !== 8'd2) begin
      errors++;
      $display("FAIL glitch: got %0d disturbed cycles cc=%0d, want 0 and 2", bad, cc_a);
    end
  endtask

  task automatic test_illegal_blank;
    seg_a = enc(9'h049);
    tick(6);
    checks++;
    if ({illegal_a, valid_a, digit_a, blank_a, update_a, cc_a} !== {1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL illegal: got ill=%b v=%b digit=%h blank=%b upd=%b cc=%0d, want 1 0 4 0 1 3",
               illegal_a, valid_a, digit_a, blank_a, update_a, cc_a);
    end
    tick(1);
    seg_a = enc(9'h100);
    tick(6);
    checks++;
    if ({blank_a, illegal_a, valid_a, update_a, cc_a} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL blank: got blank=%b ill=%b v=%b upd=%b cc=%0d, want 1 0 0 1 4",
               blank_a, illegal_a, valid_a, update_a, cc_a);
    end
    tick(1);
  endtask

  task automatic test_decode_table;
    logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int k = 0; k < 16; k++) begin
      seg_a = enc({2'b00, codes[k]});
      tick(6);
      checks++;
      if (digit_a !== 4'(k) || valid_a !== 1'b1 || illegal_a !== 1'b0 || dp_a !== 1'b0) begin
        errors++;
        $display("FAIL decode_%0d: got digit=%h v=%b ill=%b dp=%b, want %h 1 0 0",
                 k, digit_a, valid_a, illegal_a, dp_a, 4'(k));
      end
      tick(1);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] want;
    for (int i = 0; i < 6; i++) begin
      seg_b = enc((i % 2 == 0) ? 9'h006 : 9'h05B);
      tick(8);
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (cc_b !== want || digit_b !== ((i % 2 == 0) ? 4'h1 : 4'h2)) begin
        errors++;
        $display("FAIL saturate_%0d: got cc=%0d digit=%h, want cc=%0d digit=%h",
                 i, cc_b, digit_b, want, (i % 2 == 0) ? 4'h1 : 4'h2);
      end
    end
  endtask

  task automatic test_active_low;
`ifdef SEG_DEC_ACTIVE_LOW_EN
    seg_a = 9'h0C0;
    tick(6);
    checks++;
    if ({digit_a, dp_a, valid_a} !== {4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL active_low: got digit=%h dp=%b v=%b, want 0 0 1", digit_a, dp_a, valid_a);
    end
    tick(1);
`endif
  endtask

  task automatic test_reset_mid_settle;
    int bad = 0;
    seg_a = enc(9'h0E6);
    tick(4);
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({digit_a, dp_a, valid_a, blank_a, illegal_a, update_a, cc_a} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_a: got digit=%h dp=%b v=%b blank=%b ill=%b upd=%b cc=%0d, want 0 0 0 1 0 0 0",
               digit_a, dp_a, valid_a, blank_a, illegal_a, update_a, cc_a);
    end
    checks++;
    if ({digit_b, valid_b, blank_b, cc_b} !== {4'h0, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid_b: got digit=%h v=%b blank=%b cc=%0d, want 0 0 1 0",
               digit_b, valid_b, blank_b, cc_b);
    end
    seg_a = enc(9'h100);
    seg_b = enc(9'h100);
    tick(2);
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (update_a !== 1'b0 || update_b !== 1'b0 || cc_a !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_update_after_reset: got %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_dp_digit();
    test_glitch();
    test_illegal_blank();
    test_decode_table();
    test_saturation();
    test_active_low();
    test_reset_mid_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/segment_led_decoder.md
Name: segment_led_decoder

Overview:
- Receive end of the on-board 9-bit segment-LED interface (MSB..LSB = S,P,G,F,E,D,C,B,A). It samples a segment pattern and waits for the pattern to stay stable. It then decodes the pattern back to a hex digit plus decimal point.
- Used as a synthesizable monitor beside the segment driver and for loopback checking of Segment_led_1/Segment_led_2 on the STEP board. One instance per digit.

Parameters:
- STABLE_CYCLES, 16, number of consecutive identical synchronized samples required before a pattern is accepted; legal range 2..65535.
- CNT_W, 8, width of the saturating change counter.

Ports:
- clk_in  input  1  system clock (25 MHz on board).
- rst_n_in  input  1  reset; asynchronous, active-low.
- seg_in  input  9  segment pattern; [8]=S digit enable (0 = digit on), [7]=P decimal point, [6:0]=GFEDCBA. Segments are active-high.
- digit  output  4  decoded hex value of the last locked legal pattern.
- dp  output  1  decimal point of the last locked pattern.
- digit_valid  output  1  high while LOCKED on a legal pattern.
- blank  output  1  high while the accepted pattern has S=1.
- illegal  output  1  high while LOCKED on a pattern that is not in the hex table.
- update  output  1  one-cycle pulse when the accepted state changes.
- change_cnt  output  CNT_W  number of update pulses, saturating at all-ones.

Behaviour:
- Reset values, held while rst_n_in=0:
  - digit=0, dp=0, digit_valid=0, blank=1, illegal=0, update=0, change_cnt=0.
  - Synchronizer flops cleared to 9'h100 (blank).
  - State=BLANK, stability counter=0.
- Input path:
  - seg_in passes through a 2-flop synchronizer; call the result s.
  - A held register h captures s. A change is the condition s!=h.
- Decode table, GFEDCBA to value:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - Any other code is illegal.
- States:
  - BLANK: accepted pattern has S=1.
  - SETTLE: pattern changed and has not yet been stable long enough.
  - LOCKED: accepted pattern has S=0.
- Transitions:
  - From any state, a change means: h<=s, counter<=0, go to SETTLE.
  - In SETTLE with no change, the counter increments. When counter==STABLE_CYCLES-1:
    - if h[8]=1, go to BLANK: blank=1, digit_valid=0, illegal=0.
    - else go to LOCKED and set dp=h[7].
    - Legal code: digit=decoded value, digit_valid=1, illegal=0.
    - Illegal code: digit keeps its last value, digit_valid=0, illegal=1.
  - A change during SETTLE restarts the count. Outputs keep their previous accepted values during SETTLE.
- update:
  - Asserted in the cycle the outputs change on acceptance, only when the accepted 9-bit pattern differs from the previously accepted one.
  - Re-accepting an identical pattern after a glitch gives no pulse.
  - change_cnt increments with update and stops at 2^CNT_W-1.
- Latency: seg_in edge to output update = 2 sync cycles + STABLE_CYCLES cycles.
- Glitches shorter than STABLE_CYCLES synchronized cycles never reach the outputs.
- Reset asserted mid-SETTLE aborts immediately to reset values. No update pulse is generated on reset release.

Optional Feature:
- Macro SEG_DEC_ACTIVE_LOW_EN.
- Defined: seg_in[7:0] is inverted at the synchronizer input (common-anode segments, active-low). S polarity is unchanged and the reset sync value is unchanged.
- Undefined: segments are active-high as described above.

Test Plan:
- STABLE_CYCLES=4. Release reset, then drive seg_in=9'h03F held. Expect after 6 cycles: digit=0, dp=0, digit_valid=1, blank=0, update pulse, change_cnt=1.
- Drive 9'h0E6 (dp + "4"). Expect digit=4, dp=1, one update pulse, change_cnt=2.
- From locked "4", apply a 9'h07F glitch for 2 cycles, then return to 9'h0E6. Expect outputs unchanged throughout and no update pulse.
- Drive 9'h049 (illegal). Expect illegal=1, digit_valid=0, digit holds 4, update pulse. Then drive 9'h100: expect blank=1, illegal=0, update pulse.
- With CNT_W=2, alternate 9'h006/9'h05B held 8 cycles each for 6 changes. Expect change_cnt saturates at 3. Assert rst_n_in mid-SETTLE: expect all outputs at reset values immediately.
- With SEG_DEC_ACTIVE_LOW_EN defined, drive 9'h0C0. Expect digit=0, dp=0, digit_valid=1.
